// File: rtl/uart_boot_loader.sv
// UART frame loader for tz80 block RAM; holds the CPU in reset while a frame loads.
// Optional macro UART_BOOT_LOADER_ACK_EN adds a 'K'/'E' acknowledge byte on tx.
module uart_boot_loader #(
    parameter int CLK_HZ  = 25000000,
    parameter int BAUD    = 230400,
    parameter int TIMEOUT = 65535
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_o_data,
    input  logic        cpu_we,
    output logic [15:0] address,
    output logic [7:0]  o_data,
    output logic        we,
    output logic        cpu_resetn,
    output logic        busy,
    output logic        error,
    output logic        tx
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {RX_HUNT, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, LEN_H, LEN_L, ADR_H, ADR_L, DATA, SUM, RELEASE} state_t;

    rx_state_t       rx_state_reg, rx_state_next;
    logic            rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic [CW-1:0]   rx_cnt_reg, rx_cnt_next;
    logic [2:0]      rx_bit_reg, rx_bit_next;
    logic [7:0]      rx_shift_reg, rx_shift_next;
    logic            rx_valid_reg, rx_valid_next, rx_ferr_reg, rx_ferr_next;

    state_t          state_reg, state_next;
    logic            busy_reg, busy_next, resetn_reg, resetn_next, error_reg, error_next;
    logic [15:0]     len_reg, len_next, load_addr_reg, load_addr_next;
    logic [7:0]      sum_reg, sum_next, sum_add;
    logic            wr_en_reg, wr_en_next;
    logic [15:0]     wr_addr_reg, wr_addr_next;
    logic [7:0]      wr_data_reg, wr_data_next;
    logic [TW-1:0]   to_cnt_reg, to_cnt_next;
    logic            go_release, release_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_state_reg <= RX_HUNT;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
            rx_valid_reg <= 1'b0;
            rx_ferr_reg  <= 1'b0;
        end else begin
            rx_meta_reg  <= rx;
            rx_sync_reg  <= rx_meta_reg;
            rx_prev_reg  <= rx_sync_reg;
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
            rx_valid_reg <= rx_valid_next;
            rx_ferr_reg  <= rx_ferr_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg + CW'(1);
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_valid_next = 1'b0;
        rx_ferr_next  = 1'b0;
        case (rx_state_reg)
            RX_HUNT: begin
                rx_cnt_next = '0;
                if (rx_prev_reg && !rx_sync_reg) rx_state_next = RX_START;
            end
            RX_START: if (rx_cnt_reg == HALF_LAST) begin
                // A high line at mid-start is treated as a glitch.
                rx_cnt_next   = '0;
                rx_bit_next   = '0;
                rx_state_next = rx_sync_reg ? RX_HUNT : RX_DATA;
            end
            RX_DATA: if (rx_cnt_reg == DIV_LAST) begin
                rx_cnt_next   = '0;
                rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
                rx_bit_next   = rx_bit_reg + 3'd1;
                if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
            end
            RX_STOP: if (rx_cnt_reg == DIV_LAST) begin
                rx_valid_next = rx_sync_reg;
                rx_ferr_next  = !rx_sync_reg;
                rx_state_next = RX_HUNT;
            end
            default: rx_state_next = RX_HUNT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            resetn_reg    <= 1'b1;
            error_reg     <= 1'b0;
            len_reg       <= '0;
            load_addr_reg <= '0;
            sum_reg       <= '0;
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            to_cnt_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            busy_reg      <= busy_next;
            resetn_reg    <= resetn_next;
            error_reg     <= error_next;
            len_reg       <= len_next;
            load_addr_reg <= load_addr_next;
            sum_reg       <= sum_next;
            wr_en_reg     <= wr_en_next;
            wr_addr_reg   <= wr_addr_next;
            wr_data_reg   <= wr_data_next;
            to_cnt_reg    <= to_cnt_next;
        end
    end

    assign sum_add = sum_reg + rx_shift_reg;

    always_comb begin
        state_next     = state_reg;
        busy_next      = busy_reg;
        resetn_next    = resetn_reg;
        error_next     = error_reg;
        len_next       = len_reg;
        load_addr_next = load_addr_reg;
        sum_next       = sum_reg;
        wr_en_next     = 1'b0;
        wr_addr_next   = wr_addr_reg;
        wr_data_next   = wr_data_reg;
        go_release     = 1'b0;
        to_cnt_next    = (state_reg == IDLE || state_reg == RELEASE || rx_valid_reg)
                         ? '0 : to_cnt_reg + TW'(1);
        case (state_reg)
            IDLE: if (rx_valid_reg && rx_shift_reg == 8'hA5) begin
                state_next  = LEN_H;
                busy_next   = 1'b1;
                resetn_next = 1'b0;
                error_next  = 1'b0;
                sum_next    = '0;
            end
            LEN_H: if (rx_valid_reg) begin
                len_next[15:8] = rx_shift_reg;
                sum_next       = sum_add;
                state_next     = LEN_L;
            end
            LEN_L: if (rx_valid_reg) begin
                len_next[7:0] = rx_shift_reg;
                sum_next      = sum_add;
                state_next    = ADR_H;
            end
            ADR_H: if (rx_valid_reg) begin
                load_addr_next[15:8] = rx_shift_reg;
                sum_next             = sum_add;
                state_next           = ADR_L;
            end
            ADR_L: if (rx_valid_reg) begin
                load_addr_next[7:0] = rx_shift_reg;
                sum_next            = sum_add;
                state_next          = (len_reg != 16'd0) ? DATA : SUM;
            end
            DATA: if (rx_valid_reg) begin
                wr_en_next     = 1'b1;
                wr_addr_next   = load_addr_reg;
                wr_data_next   = rx_shift_reg;
                load_addr_next = load_addr_reg + 16'd1;
                len_next       = len_reg - 16'd1;
                sum_next       = sum_add;
                if (len_reg == 16'd1) state_next = SUM;
            end
            SUM: if (rx_valid_reg) begin
                error_next = (sum_add != 8'h00);
                go_release = 1'b1;
            end
            RELEASE: if (release_done) begin
                state_next  = IDLE;
                busy_next   = 1'b0;
                resetn_next = 1'b1;
            end
            default: state_next = IDLE;
        endcase
        // Framing errors and inter-byte silence abort any frame in flight.
        if (state_reg != IDLE && state_reg != RELEASE) begin
            if (rx_ferr_reg || (!rx_valid_reg && to_cnt_reg == TO_LAST)) begin
                error_next = 1'b1;
                go_release = 1'b1;
            end
        end
        if (go_release) state_next = RELEASE;
    end

`ifdef UART_BOOT_LOADER_ACK_EN
    logic [9:0]    tx_shift_reg;
    logic [CW-1:0] tx_cnt_reg;
    logic [3:0]    tx_bits_reg;
    logic          tx_busy_reg;

    // The acknowledge byte is loaded on the same edge that enters RELEASE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_shift_reg <= '1;
            tx_cnt_reg   <= '0;
            tx_bits_reg  <= '0;
            tx_busy_reg  <= 1'b0;
        end else if (go_release) begin
            tx_shift_reg <= {1'b1, (error_next ? 8'h45 : 8'h4B), 1'b0};
            tx_cnt_reg   <= '0;
            tx_bits_reg  <= '0;
            tx_busy_reg  <= 1'b1;
        end else if (tx_busy_reg) begin
            if (tx_cnt_reg == DIV_LAST) begin
                tx_cnt_reg   <= '0;
                tx_shift_reg <= {1'b1, tx_shift_reg[9:1]};
                tx_bits_reg  <= tx_bits_reg + 4'd1;
                if (tx_bits_reg == 4'd9) tx_busy_reg <= 1'b0;
            end else begin
                tx_cnt_reg <= tx_cnt_reg + CW'(1);
            end
        end
    end

    assign tx           = tx_busy_reg ? tx_shift_reg[0] : 1'b1;
    assign release_done = !tx_busy_reg;
`else
    assign tx           = 1'b1;
    assign release_done = 1'b1;
`endif

    assign busy       = busy_reg;
    assign error      = error_reg;
    assign cpu_resetn = resetn_reg;
    assign address    = busy_reg ? wr_addr_reg : cpu_address;
    assign o_data     = busy_reg ? wr_data_reg : cpu_o_data;
    assign we         = busy_reg ? wr_en_reg   : cpu_we;
endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader (default build): frames driven bit by bit on rx.
module tb_uart_boot_loader;
    localparam int CLK_HZ  = 160;
    localparam int BAUD    = 10;
    localparam int TIMEOUT = 400;
    localparam int DIV     = CLK_HZ / BAUD;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic [15:0] cpu_address = '0;
    logic [7:0]  cpu_o_data = '0;
    logic        cpu_we = 1'b0;
    logic [15:0] address;
    logic [7:0]  o_data;
    logic        we, cpu_resetn, busy, error, tx;

    int n_compared = 0;
    int n_mismatched = 0;
    logic [15:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    logic        resetn_seen_high = 1'b0;

    uart_boot_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .rx(rx),
        .cpu_address(cpu_address), .cpu_o_data(cpu_o_data), .cpu_we(cpu_we),
        .address(address), .o_data(o_data), .we(we),
        .cpu_resetn(cpu_resetn), .busy(busy), .error(error), .tx(tx)
    );

    always #5 clock = ~clock;

    // Loader writes are logged once per clock they are seen, so a stretched pulse shows up as an extra entry.
    always @(negedge clock) begin
        if (busy && we) begin
            wr_addr_q.push_back(address);
            wr_data_q.push_back(o_data);
        end
        if (busy && cpu_resetn) resetn_seen_high = 1'b1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        wait_clk(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clk(DIV);
        end
        rx = stop_bit;
        wait_clk(DIV);
        rx = 1'b1;
        wait_clk(DIV);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        resetn_seen_high = 1'b0;
    endtask

    task automatic check_write(input string tag, input int idx, input logic [15:0] a, input logic [7:0] d);
        if (wr_addr_q.size() > idx) begin
            check_val({tag, " addr"}, {16'h0, wr_addr_q[idx]}, {16'h0, a});
            check_val({tag, " data"}, {24'h0, wr_data_q[idx]}, {24'h0, d});
        end else begin
            check_val({tag, " present"}, wr_addr_q.size(), idx + 1);
        end
    endtask

    initial begin
        // Reset state
        wait_clk(3);
        check_val("rst cpu_resetn", cpu_resetn, 1);
        check_val("rst busy", busy, 0);
        check_val("rst error", error, 0);
        check_val("rst we", we, 0);
        check_val("rst tx", tx, 1);
        reset = 1'b0;
        wait_clk(2 * DIV);
        $display("txn reset: done");

        // Zero-latency pass-through while idle
        cpu_we = 1'b1; cpu_address = 16'h4000; cpu_o_data = 8'h77;
        #1;
        check_val("pass we", we, 1);
        check_val("pass address", address, 16'h4000);
        check_val("pass o_data", o_data, 8'h77);
        @(negedge clock);
        cpu_we = 1'b0; cpu_address = '0; cpu_o_data = '0;
        $display("txn passthrough: done");

        // Non-sync bytes in IDLE are ignored
        clear_log();
        send_byte(8'h00, 1'b1);
        send_byte(8'h5A, 1'b1);
        check_val("noise busy", busy, 0);
        check_val("noise writes", wr_addr_q.size(), 0);
        $display("txn noise 00 5A: done");

        // Framing error on LEN_L aborts the frame
        clear_log();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b0);
        check_val("ferr error", error, 1);
        check_val("ferr busy", busy, 0);
        check_val("ferr cpu_resetn", cpu_resetn, 1);
        check_val("ferr writes", wr_addr_q.size(), 0);
        $display("txn framing error: done");

        // Good frame: 00+02+12+34+AA+55 = 0x147, so SUM=0xB9 brings the total to 0x00
        clear_log();
        send_byte(8'hA5, 1'b1);
        check_val("good start busy", busy, 1);
        check_val("good start cpu_resetn", cpu_resetn, 0);
        check_val("good start error cleared", error, 0);
        send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
        send_byte(8'hAA, 1'b1); send_byte(8'h55, 1'b1);
        send_byte(8'hB9, 1'b1);
        check_val("good writes", wr_addr_q.size(), 2);
        check_write("good w0", 0, 16'h1234, 8'hAA);
        check_write("good w1", 1, 16'h1235, 8'h55);
        check_val("good error", error, 0);
        check_val("good busy", busy, 0);
        check_val("good cpu_resetn", cpu_resetn, 1);
        check_val("good resetn held low", resetn_seen_high, 0);
        $display("txn frame A5 00 02 12 34 AA 55 B9: done");

        // Bad checksum: bytes still written, error flagged
        clear_log();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
        send_byte(8'hAA, 1'b1); send_byte(8'h55, 1'b1);
        send_byte(8'hBA, 1'b1);
        check_val("badsum writes", wr_addr_q.size(), 2);
        check_write("badsum w1", 1, 16'h1235, 8'h55);
        check_val("badsum error", error, 1);
        check_val("badsum busy", busy, 0);
        check_val("badsum cpu_resetn", cpu_resetn, 1);
        $display("txn frame A5 00 02 12 34 AA 55 BA: done");

        // Address wrap: 02+FF+FF+11+22 = 0x233, SUM=0xCD
        clear_log();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'hFF, 1'b1); send_byte(8'hFF, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        send_byte(8'hCD, 1'b1);
        check_write("wrap w0", 0, 16'hFFFF, 8'h11);
        check_write("wrap w1", 1, 16'h0000, 8'h22);
        check_val("wrap error", error, 0);
        $display("txn frame A5 00 02 FF FF 11 22 CD: done");

        // Inter-byte timeout
        clear_log();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
        wait_clk(TIMEOUT - 60);
        check_val("timeout not yet", busy, 1);
        wait_clk(80);
        check_val("timeout error", error, 1);
        check_val("timeout busy", busy, 0);
        check_val("timeout cpu_resetn", cpu_resetn, 1);
        check_val("timeout writes", wr_addr_q.size(), 0);
        $display("txn timeout A5 00 01: done");

        // Reset mid-DATA aborts at once; later bytes are not written
        clear_log();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h20, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h33, 1'b1);
        check_val("midrst busy before", busy, 1);
        #2 reset = 1'b1;
        #1;
        check_val("midrst we", we, 0);
        check_val("midrst cpu_resetn", cpu_resetn, 1);
        check_val("midrst busy", busy, 0);
        @(negedge clock);
        reset = 1'b0;
        send_byte(8'h44, 1'b1);
        check_val("midrst writes", wr_addr_q.size(), 1);
        check_write("midrst w0", 0, 16'h2000, 8'h33);
        $display("txn reset mid-DATA: done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
